// File: rtl/riscv_pkg.sv
// Shared definitions for the multi-cycle RV64I-subset datapath: encodings,
// ALU operations, FSM states and the instruction decoder.
package riscv_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_ADDI    = 3'b000;
    localparam logic [2:0] F3_DWORD   = 3'b011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        K_ILLEGAL = 3'd0,
        K_RTYPE   = 3'd1,
        K_ADDI    = 3'd2,
        K_LOAD    = 3'd3,
        K_STORE   = 3'd4
    } kind_e;

    typedef struct packed {
        kind_e   kind;
        alu_op_e alu_op;
    } decoded_t;

    // Anything not explicitly recognised decodes as illegal.
    function automatic decoded_t decode(input logic [6:0] opcode,
                                        input logic [2:0] funct3,
                                        input logic [6:0] funct7);
        decoded_t d;
        d.kind   = K_ILLEGAL;
        d.alu_op = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                if (funct3 == F3_ADD_SUB && funct7 == F7_BASE) begin
                    d.kind = K_RTYPE; d.alu_op = ALU_ADD;
                end else if (funct3 == F3_ADD_SUB && funct7 == F7_SUB) begin
                    d.kind = K_RTYPE; d.alu_op = ALU_SUB;
                end else if (funct3 == F3_AND && funct7 == F7_BASE) begin
                    d.kind = K_RTYPE; d.alu_op = ALU_AND;
                end else if (funct3 == F3_OR && funct7 == F7_BASE) begin
                    d.kind = K_RTYPE; d.alu_op = ALU_OR;
                end
            end
            OP_IMM:   if (funct3 == F3_ADDI)  d.kind = K_ADDI;
            OP_LOAD:  if (funct3 == F3_DWORD) d.kind = K_LOAD;
            OP_STORE: if (funct3 == F3_DWORD) d.kind = K_STORE;
            default:  d.kind = K_ILLEGAL;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU; arithmetic wraps modulo 2^WORDSIZE.
module alu
    import riscv_pkg::*;
#(
    parameter int WORDSIZE = 64
) (
    input  logic [WORDSIZE-1:0] a,
    input  logic [WORDSIZE-1:0] b,
    input  alu_op_e             operation,
    output logic [WORDSIZE-1:0] result
);
    // Select the operation result.
    always_comb begin
        result = '0;
        case (operation)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            default: result = '0;
        endcase
    end
endmodule

// File: rtl/data_memory.sv
// Doubleword-indexed data memory with combinational read and clocked write.
module data_memory #(
    parameter int WORDSIZE = 64,
    parameter int SIZE     = 512,
    parameter int ADDR_W   = $clog2(SIZE)
) (
    input  logic                clk,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [WORDSIZE-1:0] write_data,
    input  logic                write_en,
    output logic [WORDSIZE-1:0] read_data
);
    logic [WORDSIZE-1:0] mem [SIZE];

    // Memory write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (write_en) mem[addr] <= write_data;
    end

    assign read_data = mem[addr];
endmodule

// File: rtl/general_mux.sv
// Two-input word multiplexer.
module general_mux #(
    parameter int WORDSIZE = 64
) (
    input  logic [WORDSIZE-1:0] in0,
    input  logic [WORDSIZE-1:0] in1,
    input  logic                sel,
    output logic [WORDSIZE-1:0] out
);
    assign out = sel ? in1 : in0;
endmodule

// File: rtl/mc_control.sv
// Multi-cycle controller: instruction FSM plus decoder driving datapath
// selects, load enables and write enables.
//
//  state        | meaning
//  -------------+-----------------------------------------------------
//  ST_IDLE      | ready for a new instruction; IR loads on handshake
//  ST_DECODE    | operands latched into A/B, unsupported -> illegal
//  ST_EXECUTE   | ALUOUT computed; ld/sd alignment checked
//  ST_MEMORY    | ld captures MDR, sd writes memory and retires
//  ST_WRITEBACK | register write (unless rd==x0) and retire
module mc_control
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       rd_zero,
    input  logic [2:0] alu_low,
    output state_e     state,
    output logic       instr_ready,
    output logic       ir_load,
    output logic       ab_load,
    output logic       aluout_load,
    output logic       mdr_load,
    output logic       alu_src_imm,
    output logic       wb_src_mdr,
    output alu_op_e    alu_operation,
    output logic       rf_write_en,
    output logic       dm_write_en,
    output logic       done,
    output logic       illegal_instr,
    output logic       misaligned
);
    state_e   state_d;
    decoded_t dec;

    assign dec = decode(opcode, funct3, funct7);

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_d;
    end

    // Next-state and control decode. Reset suppresses every commit and pulse
    // so an instruction caught mid-flight is abandoned silently.
    always_comb begin
        state_d       = state;
        instr_ready   = 1'b0;
        ir_load       = 1'b0;
        ab_load       = 1'b0;
        aluout_load   = 1'b0;
        mdr_load      = 1'b0;
        alu_src_imm   = 1'b0;
        wb_src_mdr    = 1'b0;
        alu_operation = ALU_ADD;
        rf_write_en   = 1'b0;
        dm_write_en   = 1'b0;
        done          = 1'b0;
        illegal_instr = 1'b0;
        misaligned    = 1'b0;
        case (state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    ir_load = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec.kind == K_ILLEGAL) begin
                    illegal_instr = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    ab_load = 1'b1;
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                aluout_load   = 1'b1;
                alu_operation = dec.alu_op;
                alu_src_imm   = (dec.kind != K_RTYPE);
                if (dec.kind == K_LOAD || dec.kind == K_STORE) begin
                    if (alu_low != 3'd0) begin
                        misaligned = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        state_d = ST_MEMORY;
                    end
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_MEMORY: begin
                if (dec.kind == K_LOAD) begin
                    mdr_load = 1'b1;
                    state_d  = ST_WRITEBACK;
                end else begin
                    dm_write_en = 1'b1;
                    done        = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_WRITEBACK: begin
                wb_src_mdr  = (dec.kind == K_LOAD);
                rf_write_en = !rd_zero;
                done        = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (!rst_n) begin
            instr_ready   = 1'b0;
            rf_write_en   = 1'b0;
            dm_write_en   = 1'b0;
            done          = 1'b0;
            illegal_instr = 1'b0;
            misaligned    = 1'b0;
        end
    end
endmodule

// File: rtl/register_file.sv
// 32-entry register file, two combinational read ports, one write port.
// x0 always reads as zero.
module register_file #(
    parameter int WORDSIZE = 64
) (
    input  logic                clk,
    input  logic [4:0]          read_addr1,
    input  logic [4:0]          read_addr2,
    input  logic [4:0]          write_addr,
    input  logic [WORDSIZE-1:0] write_data,
    input  logic                write_en,
    output logic [WORDSIZE-1:0] read_data1,
    output logic [WORDSIZE-1:0] read_data2
);
    logic [WORDSIZE-1:0] regs [32];

    // Register write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (write_en) regs[write_addr] <= write_data;
    end

    assign read_data1 = (read_addr1 == 5'd0) ? '0 : regs[read_addr1];
    assign read_data2 = (read_addr2 == 5'd0) ? '0 : regs[read_addr2];
endmodule

// File: rtl/multicycle_datapath.sv
// Multi-cycle RV64I-subset datapath: IR/A/B/ALUOUT/MDR registers, immediate
// generation, register file, data memory, ALU and operand muxes sequenced by
// mc_control.
module multicycle_datapath
    import riscv_pkg::*;
#(
    parameter int WORDSIZE = 64,
    parameter int SIZE     = 512,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         instr,
    input  logic                instr_valid,
    output logic                instr_ready,
    output logic                done,
    output logic                illegal_instr,
    output logic                misaligned,
    output logic [CNT_W-1:0]    instret,
    output logic [2:0]          dbg_state,
    output logic [WORDSIZE-1:0] dbg_alu_out
);
    localparam int DM_AW = $clog2(SIZE);

    logic [31:0]         ir;
    logic [WORDSIZE-1:0] a_q, b_q, aluout_q, mdr_q;
    logic [WORDSIZE-1:0] imm, rs1_data, rs2_data, alu_b, alu_result, wb_data, dm_rdata;
    logic [6:0]          opcode, funct7;
    logic [2:0]          funct3;
    logic [4:0]          rs1, rs2, rd;

    state_e  state;
    alu_op_e alu_operation;
    logic    ir_load, ab_load, aluout_load, mdr_load;
    logic    alu_src_imm, wb_src_mdr, rf_write_en, dm_write_en;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];

    // Stores carry the S-type split immediate; everything else uses I-type.
    assign imm = (opcode == OP_STORE)
               ? {{(WORDSIZE-12){ir[31]}}, ir[31:25], ir[11:7]}
               : {{(WORDSIZE-12){ir[31]}}, ir[31:20]};

    mc_control u_ctrl (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_valid   (instr_valid),
        .opcode        (opcode),
        .funct3        (funct3),
        .funct7        (funct7),
        .rd_zero       (rd == 5'd0),
        .alu_low       (alu_result[2:0]),
        .state         (state),
        .instr_ready   (instr_ready),
        .ir_load       (ir_load),
        .ab_load       (ab_load),
        .aluout_load   (aluout_load),
        .mdr_load      (mdr_load),
        .alu_src_imm   (alu_src_imm),
        .wb_src_mdr    (wb_src_mdr),
        .alu_operation (alu_operation),
        .rf_write_en   (rf_write_en),
        .dm_write_en   (dm_write_en),
        .done          (done),
        .illegal_instr (illegal_instr),
        .misaligned    (misaligned)
    );

    register_file #(.WORDSIZE(WORDSIZE)) u_rf (
        .clk        (clk),
        .read_addr1 (rs1),
        .read_addr2 (rs2),
        .write_addr (rd),
        .write_data (wb_data),
        .write_en   (rf_write_en),
        .read_data1 (rs1_data),
        .read_data2 (rs2_data)
    );

    general_mux #(.WORDSIZE(WORDSIZE)) u_mux_alu_b (
        .in0 (b_q),
        .in1 (imm),
        .sel (alu_src_imm),
        .out (alu_b)
    );

    alu #(.WORDSIZE(WORDSIZE)) u_alu (
        .a         (a_q),
        .b         (alu_b),
        .operation (alu_operation),
        .result    (alu_result)
    );

    data_memory #(.WORDSIZE(WORDSIZE), .SIZE(SIZE), .ADDR_W(DM_AW)) u_dm (
        .clk        (clk),
        .addr       (aluout_q[3 +: DM_AW]),
        .write_data (b_q),
        .write_en   (dm_write_en),
        .read_data  (dm_rdata)
    );

    general_mux #(.WORDSIZE(WORDSIZE)) u_mux_wb (
        .in0 (aluout_q),
        .in1 (mdr_q),
        .sel (wb_src_mdr),
        .out (wb_data)
    );

    // Pipeline-free datapath registers, each loaded in its owning state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ir       <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
            mdr_q    <= '0;
        end else begin
            if (ir_load)     ir       <= instr;
            if (ab_load)     a_q      <= rs1_data;
            if (ab_load)     b_q      <= rs2_data;
            if (aluout_load) aluout_q <= alu_result;
            if (mdr_load)    mdr_q    <= dm_rdata;
        end
    end

    // Retired-instruction counter; wraps naturally.
    always_ff @(posedge clk) begin
        if (!rst_n)    instret <= '0;
        else if (done) instret <= instret + CNT_W'(1);
    end

    assign dbg_state   = state;
    assign dbg_alu_out = aluout_q;
endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed testbench for multicycle_datapath. Register and memory contents
// are read back through "addi x0, xN, 0", which exposes xN on dbg_alu_out
// without modifying any architectural state other than instret.
module tb_multicycle_datapath;
    localparam int WORDSIZE = 64;
    localparam int SIZE     = 512;
    localparam int CNT_W    = 32;

    localparam logic [2:0] P_DONE = 3'b100;
    localparam logic [2:0] P_ILL  = 3'b010;
    localparam logic [2:0] P_MIS  = 3'b001;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [31:0]         instr = '0;
    logic                instr_valid = 1'b0;
    logic                instr_ready, done, illegal_instr, misaligned;
    logic [CNT_W-1:0]    instret;
    logic [2:0]          dbg_state;
    logic [WORDSIZE-1:0] dbg_alu_out;

    int               n_cmp = 0;
    int               n_err = 0;
    logic [CNT_W-1:0] exp_instret = '0;

    multicycle_datapath #(.WORDSIZE(WORDSIZE), .SIZE(SIZE), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .done          (done),
        .illegal_instr (illegal_instr),
        .misaligned    (misaligned),
        .instret       (instret),
        .dbg_state     (dbg_state),
        .dbg_alu_out   (dbg_alu_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [11:0] imm);
        return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
    endfunction

    function automatic logic [31:0] enc_ld(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [11:0] imm);
        return enc_i(imm, rs1, 3'b011, rd, 7'b0000011);
    endfunction

    function automatic logic [31:0] enc_sd(input logic [4:0] rs2, input logic [4:0] rs1,
                                           input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    // Issue one instruction from a negedge in IDLE; latency counts the accept
    // cycle as 1. Returns at the first negedge back in IDLE.
    task automatic exec(input string tag, input logic [31:0] ins, input int exp_lat,
                        input logic [2:0] exp_pulse, input logic [63:0] exp_alu,
                        input bit chk_alu);
        int         lat;
        logic [2:0] pulse;
        check_eq({tag, "/ready"}, 64'(instr_ready), 64'd1);
        instr       = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = '0;
        lat   = 2;
        pulse = 3'b000;
        for (int i = 0; i < 12; i++) begin
            pulse = {done, illegal_instr, misaligned};
            if (pulse != 3'b000) break;
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "/pulse"}, 64'(pulse), 64'(exp_pulse));
        check_eq({tag, "/latency"}, 64'(lat), 64'(exp_lat));
        if (exp_pulse == P_DONE) exp_instret = exp_instret + CNT_W'(1);
        @(negedge clk);
        check_eq({tag, "/state"}, 64'(dbg_state), 64'd0);
        check_eq({tag, "/instret"}, 64'(instret), 64'(exp_instret));
        if (chk_alu) check_eq({tag, "/alu_out"}, dbg_alu_out, exp_alu);
    endtask

    task automatic readback(input string tag, input logic [4:0] r, input logic [63:0] exp);
        exec(tag, enc_addi(5'd0, r, 12'd0), 4, P_DONE, exp, 1'b1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst/state", 64'(dbg_state), 64'd0);
        check_eq("rst/ready_low", 64'(instr_ready), 64'd0);
        check_eq("rst/done", 64'(done), 64'd0);
        check_eq("rst/instret", 64'(instret), 64'd0);
        check_eq("rst/alu_out", dbg_alu_out, 64'd0);
        rst_n = 1'b1;
        #1;
        check_eq("rst/ready_high", 64'(instr_ready), 64'd1);

        // addi/addi/add
        exec("addi_x1", enc_addi(5'd1, 5'd0, 12'd5), 4, P_DONE, 64'd5, 1'b1);
        exec("addi_x2", enc_addi(5'd2, 5'd0, 12'hFFD), 4, P_DONE, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1);
        exec("add_x3", enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3), 4, P_DONE, 64'd2, 1'b1);
        check_eq("t1/instret3", 64'(instret), 64'd3);
        readback("rd_x3", 5'd3, 64'd2);

        // store then load
        exec("sd_x1", enc_sd(5'd1, 5'd0, 12'd8), 4, P_DONE, 64'd8, 1'b1);
        exec("ld_x4", enc_ld(5'd4, 5'd0, 12'd8), 5, P_DONE, 64'd8, 1'b1);
        readback("rd_x4", 5'd4, 64'd5);

        // x0 write suppression, sub, and, or
        exec("addi_x0", enc_addi(5'd0, 5'd0, 12'd7), 4, P_DONE, 64'd7, 1'b1);
        readback("rd_x0", 5'd0, 64'd0);
        exec("sub_x5", enc_r(7'b0100000, 5'd1, 5'd0, 3'b000, 5'd5), 4, P_DONE,
             64'hFFFF_FFFF_FFFF_FFFB, 1'b1);
        readback("rd_x5", 5'd5, 64'hFFFF_FFFF_FFFF_FFFB);
        exec("or_x8", enc_r(7'b0000000, 5'd2, 5'd1, 3'b110, 5'd8), 4, P_DONE,
             64'hFFFF_FFFF_FFFF_FFFD, 1'b1);
        exec("and_x9", enc_r(7'b0000000, 5'd2, 5'd1, 3'b111, 5'd9), 4, P_DONE, 64'd5, 1'b1);

        // illegal encodings: pulse in DECODE, nothing retired
        exec("ill_zero", 32'h0000_0000, 2, P_ILL, 64'd0, 1'b0);
        exec("ill_f7", enc_r(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3), 2, P_ILL, 64'd0, 1'b0);
        exec("ill_lw", enc_i(12'd8, 5'd0, 3'b010, 5'd4, 7'b0000011), 2, P_ILL, 64'd0, 1'b0);
        readback("rd_x3_kept", 5'd3, 64'd2);
        readback("rd_x4_kept", 5'd4, 64'd5);

        // misaligned ld/sd: pulse in EXECUTE, no register or memory write
        exec("addi_x6", enc_addi(5'd6, 5'd0, 12'd11), 4, P_DONE, 64'd11, 1'b1);
        exec("ld_mis", enc_ld(5'd6, 5'd0, 12'd3), 3, P_MIS, 64'd3, 1'b1);
        readback("rd_x6_kept", 5'd6, 64'd11);
        exec("sd_mis", enc_sd(5'd2, 5'd0, 12'd12), 3, P_MIS, 64'd12, 1'b1);
        exec("ld_x10", enc_ld(5'd10, 5'd0, 12'd8), 5, P_DONE, 64'd8, 1'b1);
        readback("rd_x10", 5'd10, 64'd5);

        // reset during WRITEBACK abandons the instruction
        exec("addi_x7", enc_addi(5'd7, 5'd0, 12'd1), 4, P_DONE, 64'd1, 1'b1);
        instr       = enc_addi(5'd7, 5'd0, 12'd9);
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = '0;
        for (int i = 0; i < 12 && dbg_state != 3'd4; i++) @(negedge clk);
        check_eq("t6/in_wb", 64'(dbg_state), 64'd4);
        rst_n = 1'b0;
        #1;
        check_eq("t6/done_gated", 64'(done), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check_eq("t6/state", 64'(dbg_state), 64'd0);
        check_eq("t6/instret", 64'(instret), 64'd0);
        check_eq("t6/ready_low", 64'(instr_ready), 64'd0);
        check_eq("t6/alu_out", dbg_alu_out, 64'd0);
        exp_instret = '0;
        rst_n = 1'b1;
        #1;
        check_eq("t6/ready_high", 64'(instr_ready), 64'd1);
        readback("rd_x7_kept", 5'd7, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
